// File: rtl/subtractor16_serial.sv
// Nibble-serial 16-bit subtractor: D = A - B - Bin, one 4-bit slice per clock.
// Operands are captured on the accepting edge. Four RUN cycles then ripple the
// borrow through the slices. Results and flags update only on the edge that
// enters DONE, and they hold until the next completion.
module subtractor16_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] D,
  output logic        Bout,
  output logic        Z,
  output logic        N,
  output logic        V
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  slice_cnt;   // index of the slice computed on the next RUN edge
  logic [15:0] a_q;         // latched minuend
  logic [15:0] b_q;         // latched subtrahend
  logic [15:0] diff_q;      // partial difference, filled slice by slice
  logic        carry_q;     // carry into the current slice (inverted borrow)

  logic [3:0]  a_k;
  logic [3:0]  b_k;
  logic [4:0]  slice_sum;   // {carry_out, difference nibble}
  logic [15:0] diff_nxt;    // diff_q with the current slice merged in
  logic        accept;
  logic        last_slice;

  // Operands are sampled only when idle or in the completion cycle; a start
  // during RUN is ignored so the operation in flight stays undisturbed.
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last_slice = (state == RUN) && (slice_cnt == 2'd3);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Select the current nibble of each operand and add with the inverted
  // subtrahend: A_k + ~B_k + carry is A_k - B_k - borrow in carry form.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    a_k      = a_q[3:0];
    b_k      = b_q[3:0];
    diff_nxt = diff_q;
    case (slice_cnt)
      2'd0: begin a_k = a_q[3:0];   b_k = b_q[3:0];   end
      2'd1: begin a_k = a_q[7:4];   b_k = b_q[7:4];   end
      2'd2: begin a_k = a_q[11:8];  b_k = b_q[11:8];  end
      default: begin a_k = a_q[15:12]; b_k = b_q[15:12]; end
    endcase
    slice_sum = {1'b0, a_k} + {1'b0, ~b_k} + {4'b0000, carry_q};
    case (slice_cnt)
      2'd0:    diff_nxt[3:0]   = slice_sum[3:0];
      2'd1:    diff_nxt[7:4]   = slice_sum[3:0];
      2'd2:    diff_nxt[11:8]  = slice_sum[3:0];
      default: diff_nxt[15:12] = slice_sum[3:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on start, four RUN slices, a one-cycle DONE
  // that may immediately accept a back-to-back request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (last_slice) state_nxt = DONE;
      DONE: state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and slice datapath. This logic latches operands on accept
  // and advances one nibble per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      carry_q   <= 1'b0;
      slice_cnt <= 2'd0;
    end else if (accept) begin
      a_q       <= A;
      b_q       <= B;
      diff_q    <= '0;
      carry_q   <= ~Bin;
      slice_cnt <= 2'd0;
    end else if (state == RUN) begin
      diff_q    <= diff_nxt;
      carry_q   <= slice_sum[4];
      slice_cnt <= slice_cnt + 2'd1;
    end
  end

  // Result and flag registers: updated only on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D    <= '0;
      Bout <= 1'b0;
      Z    <= 1'b0;
      N    <= 1'b0;
      V    <= 1'b0;
    end else if (last_slice) begin
      D    <= diff_nxt;
      Bout <= ~slice_sum[4];
      Z    <= (diff_nxt == 16'h0000);
      N    <= diff_nxt[15];
      V    <= (a_q[15] ^ b_q[15]) & (diff_nxt[15] ^ a_q[15]);
    end
  end

endmodule

// File: tb/tb_subtractor16_serial.sv
// Scoreboard bench for subtractor16_serial. The driver pushes hand-computed
// expected results as it issues requests. A monitor compares each done pulse
// against the front of the queue, and it also checks latency and busy length.
module tb_subtractor16_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        busy;
  logic        done;
  logic [15:0] D;
  logic        Bout;
  logic        Z;
  logic        N;
  logic        V;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        z;
    logic        n;
    logic        v;
    int          accept_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   busy_len = 0;

  subtractor16_serial dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .Z     (Z),
    .N     (N),
    .V     (V)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy || done) check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (busy) begin
        busy_len = busy_len + 1;
      end else if (done) begin
        done_seen++;
        check("busy_cycles", busy_len, 4);
        busy_len = 0;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("D",       {16'd0, D},     {16'd0, e.d});
          check("Bout",    {31'd0, Bout},  {31'd0, e.bout});
          check("Z",       {31'd0, Z},     {31'd0, e.z});
          check("N",       {31'd0, N},     {31'd0, e.n});
          check("V",       {31'd0, V},     {31'd0, e.v});
          check("latency", cyc - e.accept_cyc, 4);
        end
      end else begin
        busy_len = 0;
      end
    end else begin
      busy_len = 0;
    end
  end

  // Queue an expected result whose accepting edge is 'ahead' posedges away.
  task automatic expect_result(input logic [15:0] d, input logic bo, input logic z,
                               input logic n, input logic v, input int ahead);
    exp_t e;
    e.d = d; e.bout = bo; e.z = z; e.n = n; e.v = v;
    e.accept_cyc = cyc + ahead;
    sb.push_back(e);
  endtask

  // Single-cycle start pulse, then let the operation drain back to IDLE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] d, input logic bo, input logic z,
                        input logic n, input logic v);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    expect_result(d, bo, z, n, v, 1);
    @(negedge clk);
    start = 1'b0;
    A = 16'hDEAD; B = 16'hBEEF; Bin = 1'b1;   // operands may change after accept
    repeat (6) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_D",    {16'd0, D},    32'd0);
    check("reset_flags", {28'd0, Bout, Z, N, V}, 32'd0);
    reset = 1'b0;

    //      A        B        Bin   D        Bout  Z     N     V
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    run_op(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back: start held across two operations, accepts 5 edges apart.
    @(negedge clk);
    A = 16'd3; B = 16'd5; Bin = 1'b0; start = 1'b1;
    expect_result(16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    expect_result(16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    @(negedge clk);
    A = 16'd5; B = 16'd3;
    repeat (5) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Start re-asserted in the 2nd RUN cycle with other operands: ignored.
    @(negedge clk);
    A = 16'h1111; B = 16'h0101; Bin = 1'b0; start = 1'b1;
    expect_result(16'h1010, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = '0; B = '0;
    repeat (8) @(negedge clk);

    // Reset after two slices: outputs clear at once and no done follows.
    @(negedge clk);
    A = 16'hAAAA; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_D",    {16'd0, D},    32'd0);
    check("abort_flags", {28'd0, Bout, Z, N, V}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_seen, 8);

    run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    check("done_count", done_seen, 9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
